// File: rtl/unshuffle_stream.sv
// Pixel-unshuffle (space-to-depth, factor 2) image loader.
// Takes a raster-order single-channel image over valid/ready and writes it into
// four activation SRAM banks as four unshuffled channels. Each group of four
// horizontally adjacent pixels becomes one masked word write.
module unshuffle_stream #(
  parameter int BW_PER_ACT  = 8,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int ADDR_W      = 6,
  parameter int ADDR_STRIDE = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [BW_PER_ACT-1:0]    in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               sram_wen,
  output logic [15:0]              sram_bytemask,
  output logic [ADDR_W-1:0]        sram_waddr,
  output logic [16*BW_PER_ACT-1:0] sram_wdata
);

  // Counters are at least 3 bits so row[2]/col[2] exist even for 4-pixel images.
  localparam int CW = ($clog2(IMG_W) < 3) ? 3 : $clog2(IMG_W);
  localparam int RW = ($clog2(IMG_H) < 3) ? 3 : $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACT   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [BW_PER_ACT-1:0] pix_buf [3];
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  group_end;
  logic [3:0]            byte_base;
  logic [3:0]            wen_nxt;
  logic [15:0]           mask_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [16*BW_PER_ACT-1:0] data_nxt;

  assign in_ready  = (state == ACT);
  assign busy      = (state == ACT) || (state == FLUSH);
  assign done      = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  assign group_end = accept && (col[1:0] == 2'd3);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: the last accepted pixel moves to FLUSH so its write lands before DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACT;
      ACT:     if (accept && col_last && row_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position of the next pixel; cleared on start and advanced only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Holds the first three pixels of a four-pixel group; the fourth is used live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pix_buf[i] <= '0;
    end else if (accept) begin
      pix_buf[0] <= pix_buf[1];
      pix_buf[1] <= pix_buf[2];
      pix_buf[2] <= in_data;
    end
  end

  // Word for the group ending at the current pixel: even columns feed the even
  // channel of this row parity, odd columns the odd channel, two bytes each.
  always_comb begin
    byte_base = {row[0], 1'b0, row[1], 1'b0};
    wen_nxt   = 4'hF;
    wen_nxt[{row[2], col[2]}] = 1'b0;
    addr_nxt  = ADDR_W'(row >> 3) * ADDR_W'(ADDR_STRIDE) + ADDR_W'(col >> 3);
    mask_nxt  = 16'hFFFF;
    data_nxt  = '0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) == byte_base) begin
        mask_nxt[15-i] = 1'b0;
        data_nxt[(15-i)*BW_PER_ACT +: BW_PER_ACT] = pix_buf[0];
      end
      if (4'(i) == byte_base + 4'd1) begin
        mask_nxt[15-i] = 1'b0;
        data_nxt[(15-i)*BW_PER_ACT +: BW_PER_ACT] = pix_buf[2];
      end
      if (4'(i) == byte_base + 4'd4) begin
        mask_nxt[15-i] = 1'b0;
        data_nxt[(15-i)*BW_PER_ACT +: BW_PER_ACT] = pix_buf[1];
      end
      if (4'(i) == byte_base + 4'd5) begin
        mask_nxt[15-i] = 1'b0;
        data_nxt[(15-i)*BW_PER_ACT +: BW_PER_ACT] = in_data;
      end
    end
  end

  // Registered SRAM port: enables/mask idle every cycle without a write, address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_wen      <= 4'hF;
      sram_bytemask <= 16'hFFFF;
      sram_waddr    <= '0;
      sram_wdata    <= '0;
    end else begin
      sram_wen      <= 4'hF;
      sram_bytemask <= 16'hFFFF;
      if (group_end) begin
        sram_wen      <= wen_nxt;
        sram_bytemask <= mask_nxt;
        sram_waddr    <= addr_nxt;
        sram_wdata    <= data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_unshuffle_stream.sv
// Testbench for unshuffle_stream: a 28x28 and an 8x8 instance checked every
// cycle against an arithmetic model of the pixel mapping, plus literal spot checks.
module tb_unshuffle_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start_i = 2'b00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic [1:0]   ready_o, busy_o, done_o;
  logic [3:0]   wen_o  [2];
  logic [15:0]  mask_o [2];
  logic [5:0]   addr_o [2];
  logic [127:0] data_o [2];

  int vectors = 0;
  int miscompares = 0;

  int img_w [2] = '{28, 8};
  int img_h [2] = '{28, 8};
  int stride [2] = '{6, 1};

  // Model state: phase 0 idle, 1 loading, 2 flush, 3 done.
  int           m_phase [2];
  int           m_count [2];
  logic [7:0]   m_pix [2][4];
  logic         exp_ready [2], exp_busy [2], exp_done [2];
  logic [3:0]   exp_wen [2];
  logic [15:0]  exp_mask [2];
  logic [5:0]   exp_addr [2];
  logic [127:0] exp_data [2];

  int         wcount [2];
  int         dcount [2];
  logic [7:0] mem  [4][64][16];
  logic [7:0] snap [4][64][16];

  always #5 clk = ~clk;

  unshuffle_stream #(.BW_PER_ACT(8), .IMG_W(28), .IMG_H(28), .ADDR_W(6), .ADDR_STRIDE(6)) dut28 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]), .sram_wen(wen_o[0]),
    .sram_bytemask(mask_o[0]), .sram_waddr(addr_o[0]), .sram_wdata(data_o[0])
  );

  unshuffle_stream #(.BW_PER_ACT(8), .IMG_W(8), .IMG_H(8), .ADDR_W(6), .ADDR_STRIDE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]), .sram_wen(wen_o[1]),
    .sram_bytemask(mask_o[1]), .sram_waddr(addr_o[1]), .sram_wdata(data_o[1])
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_count[i] = 0;
      exp_ready[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
      exp_wen[i] = 4'hF; exp_mask[i] = 16'hFFFF;
      exp_addr[i] = '0; exp_data[i] = '0;
    end
  endtask

  task automatic model_place(input int i, input int b, input logic [7:0] v);
    exp_mask[i][15-b] = 1'b0;
    exp_data[i][(15-b)*8 +: 8] = v;
  endtask

  // One clock of the model, using the inputs as they stood before the edge.
  task automatic model_step(input int i);
    int r, c, y, k, bank, base;
    exp_wen[i]  = 4'hF;
    exp_mask[i] = 16'hFFFF;
    case (m_phase[i])
      0: if (start_i[i]) begin m_phase[i] = 1; m_count[i] = 0; end
      1: if (in_valid) begin
        r = m_count[i] / img_w[i];
        c = m_count[i] % img_w[i];
        m_pix[i][c % 4] = in_data;
        if (c % 4 == 3) begin
          y    = r / 2;
          k    = c / 4;
          bank = ((y / 2) % 2) * 2 + (k % 2);
          base = (r % 2) * 8 + (y % 2) * 2;
          exp_wen[i]  = 4'hF & ~(4'b0001 << bank);
          exp_addr[i] = 6'((y / 4) * stride[i] + k / 2);
          exp_data[i] = '0;
          model_place(i, base,     m_pix[i][0]);
          model_place(i, base + 1, m_pix[i][2]);
          model_place(i, base + 4, m_pix[i][1]);
          model_place(i, base + 5, m_pix[i][3]);
        end
        m_count[i]++;
        if (m_count[i] == img_w[i] * img_h[i]) m_phase[i] = 2;
      end
      2: m_phase[i] = 3;
      default: m_phase[i] = 0;
    endcase
    exp_ready[i] = (m_phase[i] == 1);
    exp_busy[i]  = (m_phase[i] == 1) || (m_phase[i] == 2);
    exp_done[i]  = (m_phase[i] == 3);
  endtask

  // Model evolves on clock edges and on asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Compare process: every output of both instances against the model, each cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("u%0d in_ready", i), 128'(ready_o[i]), 128'(exp_ready[i]));
        checkOutput($sformatf("u%0d busy", i), 128'(busy_o[i]), 128'(exp_busy[i]));
        checkOutput($sformatf("u%0d done", i), 128'(done_o[i]), 128'(exp_done[i]));
        checkOutput($sformatf("u%0d sram_wen", i), 128'(wen_o[i]), 128'(exp_wen[i]));
        checkOutput($sformatf("u%0d sram_bytemask", i), 128'(mask_o[i]), 128'(exp_mask[i]));
        checkOutput($sformatf("u%0d sram_waddr", i), 128'(addr_o[i]), 128'(exp_addr[i]));
        checkOutput($sformatf("u%0d sram_wdata", i), data_o[i], exp_data[i]);
        if (wen_o[i] != 4'hF) wcount[i]++;
        if (done_o[i]) dcount[i]++;
      end
      for (int b = 0; b < 4; b++)
        if (!wen_o[0][b])
          for (int j = 0; j < 16; j++)
            if (!mask_o[0][15-j]) mem[b][addr_o[0]][j] = data_o[0][(15-j)*8 +: 8];
    end
  end

  // Offers one pixel and returns at the start of the cycle after it was accepted.
  task automatic send_pixel(input int i, input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ready_o[i] && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (!ready_o[i]) begin
      checkOutput($sformatf("u%0d in_ready within 100 cycles", i), 128'(ready_o[i]), 128'(1));
      finish_run();
    end
    @(negedge clk); #1;
  endtask

  // Loads one image into instance i with gap% idle cycles; abort_at >= 0 resets mid-load.
  task automatic applyStimulus(input int i, input int gap, input int abort_at);
    int total = img_w[i] * img_h[i];
    wcount[i] = 0;
    dcount[i] = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        for (int j = 0; j < 16; j++) mem[b][a][j] = 8'h00;
    @(negedge clk); #1;
    checkOutput($sformatf("u%0d in_ready in IDLE", i), 128'(ready_o[i]), 128'(0));
    start_i[i] = 1'b1;
    @(negedge clk); #1;
    start_i[i] = 1'b0;
    for (int n = 0; n < total; n++) begin
      if (n == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("abort sram_wen", 128'(wen_o[i]), 128'(4'hF));
        checkOutput("abort sram_bytemask", 128'(mask_o[i]), 128'(16'hFFFF));
        checkOutput("abort sram_waddr", 128'(addr_o[i]), 128'(0));
        checkOutput("abort sram_wdata", data_o[i], 128'(0));
        checkOutput("abort in_ready", 128'(ready_o[i]), 128'(0));
        checkOutput("abort busy", 128'(busy_o[i]), 128'(0));
        @(negedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(negedge clk); #1;
      end
      if (n == 20) start_i[i] = 1'b1;
      send_pixel(i, 8'(n % 256));
      start_i[i] = 1'b0;
      if (i == 0 && n == 3) begin
        checkOutput("first write wen", 128'(wen_o[0]), 128'(4'b1110));
        checkOutput("first write addr", 128'(addr_o[0]), 128'(0));
        checkOutput("first write mask", 128'(mask_o[0]), 128'(16'h33FF));
        checkOutput("first write data", data_o[0], 128'h00020000_01030000_00000000_00000000);
      end
      if (i == 0 && n == 31) begin
        checkOutput("row1 write wen", 128'(wen_o[0]), 128'(4'b1110));
        checkOutput("row1 write addr", 128'(addr_o[0]), 128'(0));
        checkOutput("row1 write mask", 128'(mask_o[0]), 128'(16'hFF33));
        checkOutput("row1 write data", data_o[0], 128'h00000000_00000000_1C1E0000_1D1F0000);
      end
      if (i == 0 && n == 4 * 28 + 7) begin
        checkOutput("row4 col4 wen", 128'(wen_o[0]), 128'(4'b0111));
        checkOutput("row4 col4 addr", 128'(addr_o[0]), 128'(0));
      end
      if (i == 0 && n == 8 * 28 + 11) begin
        checkOutput("row8 col8 wen", 128'(wen_o[0]), 128'(4'b1110));
        checkOutput("row8 col8 addr", 128'(addr_o[0]), 128'(7));
      end
    end
    in_valid = 1'b0;
    checkOutput($sformatf("u%0d FLUSH in_ready", i), 128'(ready_o[i]), 128'(0));
    checkOutput($sformatf("u%0d FLUSH busy", i), 128'(busy_o[i]), 128'(1));
    checkOutput($sformatf("u%0d FLUSH done", i), 128'(done_o[i]), 128'(0));
    @(negedge clk); #1;
    checkOutput($sformatf("u%0d DONE done", i), 128'(done_o[i]), 128'(1));
    checkOutput($sformatf("u%0d DONE in_ready", i), 128'(ready_o[i]), 128'(0));
    start_i[i] = 1'b1;
    @(negedge clk); #1;
    start_i[i] = 1'b0;
    checkOutput($sformatf("u%0d after DONE done", i), 128'(done_o[i]), 128'(0));
    @(negedge clk); #1;
    checkOutput($sformatf("u%0d start in DONE ignored", i), 128'(busy_o[i]), 128'(0));
    checkOutput($sformatf("u%0d write count", i), 128'(wcount[i]), 128'(total / 4));
    checkOutput($sformatf("u%0d done count", i), 128'(dcount[i]), 128'(1));
  endtask

  // Directed sequence: reset, no-stall, stalled, small image, mid-load reset, reload.
  initial begin
    int diffs;
    #12;
    checkOutput("reset sram_wen", 128'(wen_o[0]), 128'(4'hF));
    checkOutput("reset sram_bytemask", 128'(mask_o[0]), 128'(16'hFFFF));
    checkOutput("reset sram_wdata", data_o[0], 128'(0));
    checkOutput("reset busy/done", 128'({busy_o[0], done_o[0]}), 128'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(0, 0, -1);
    snap = mem;
    applyStimulus(0, 30, -1);
    diffs = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        for (int j = 0; j < 16; j++)
          if (mem[b][a][j] !== snap[b][a][j]) diffs++;
    checkOutput("stalled image vs no-stall image byte diffs", 128'(diffs), 128'(0));

    applyStimulus(1, 0, -1);
    applyStimulus(0, 0, 50);
    applyStimulus(0, 0, -1);

    repeat (3) @(negedge clk);
    finish_run();
  end

endmodule
